// File: rtl/mining_word_loader.sv
// Message-block word loader feeding the mining FSM.
// Buffers one block of words and exposes a registered read port.
module mining_word_loader #(
  parameter int WORD_W     = 32,
  parameter int NUM_WORDS  = 16,
  parameter int ADDR_W     = 4,
  parameter bit SWAP_BYTES = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        fsm_state,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              stopw,
  output logic [ADDR_W:0]   word_count,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    FULL = 2'b10,
    BAD  = 2'b11
  } state_t;

  localparam logic [2:0] FSM_RST  = 3'b000;
  localparam logic [2:0] FSM_LOAD = 3'b001;
  localparam logic [ADDR_W:0] LAST =
    (ADDR_W+1)'(NUM_WORDS - 1);

  state_t state;

  logic [WORD_W-1:0] mem [NUM_WORDS];
  logic [WORD_W-1:0] wr_word;
  logic [ADDR_W-1:0] wr_addr;
  logic              xfer;

  assign in_ready = (state == LOAD) &&
                    (fsm_state == FSM_LOAD);
  assign xfer     = in_valid && in_ready;
  assign wr_addr  = word_count[ADDR_W-1:0];

  always_comb begin
    wr_word = in_data;
    if (SWAP_BYTES) begin
      for (int j = 0; j < WORD_W/8; j++) begin
        wr_word[8*j +: 8] = in_data[WORD_W-8-8*j +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      stopw      <= 1'b0;
      word_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fsm_state == FSM_LOAD) state <= LOAD;
        end
        LOAD: begin
          // an abort wins; in_ready is already low then
          if (fsm_state == FSM_RST) begin
            state      <= IDLE;
            word_count <= '0;
          end else if (xfer) begin
            word_count <= word_count + 1'b1;
            if (word_count == LAST) begin
              state <= FULL;
              stopw <= 1'b1;
            end
          end
        end
        FULL: begin
          if (fsm_state == FSM_RST) begin
            state      <= IDLE;
            stopw      <= 1'b0;
            word_count <= '0;
          end
        end
        BAD: begin
          state      <= IDLE;
          stopw      <= 1'b0;
          word_count <= '0;
        end
      endcase
    end
  end

  // read samples the pre-write contents on a collision
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        mem[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
      if (xfer) mem[wr_addr] <= wr_word;
    end
  end

endmodule

// File: tb/tb_mining_word_loader.sv
// Bench for mining_word_loader: plain and byte-swapping
// instances against a word-queue reference model.
module tb_mining_word_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  fsm_state = 3'b000;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic [3:0]  rd_addr = '0;

  logic        in_ready, stopw;
  logic [4:0]  word_count;
  logic [31:0] rd_data;
  logic        in_ready_s, stopw_s;
  logic [4:0]  word_count_s;
  logic [31:0] rd_data_s;

  int checks = 0;
  int errors = 0;

  bit          m_idle = 1'b1;
  int          m_cnt = 0;
  logic [31:0] m_mem [16] = '{default: 32'h0};
  logic [31:0] m_rd = '0;

  logic [2:0]  hs [4] = '{3'b010, 3'b011, 3'b100, 3'b111};
  logic [77:0] obs;

  assign obs = {in_ready, stopw, word_count, rd_data,
                in_ready_s, stopw_s, word_count_s, rd_data_s};

  mining_word_loader #(
    .WORD_W(32), .NUM_WORDS(16), .ADDR_W(4), .SWAP_BYTES(1'b0)
  ) dut (
    .clock(clock), .reset(reset), .fsm_state(fsm_state),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .stopw(stopw), .word_count(word_count),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  mining_word_loader #(
    .WORD_W(32), .NUM_WORDS(16), .ADDR_W(4), .SWAP_BYTES(1'b1)
  ) dut_s (
    .clock(clock), .reset(reset), .fsm_state(fsm_state),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_s),
    .stopw(stopw_s), .word_count(word_count_s),
    .rd_addr(rd_addr), .rd_data(rd_data_s)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic bit m_full();
    return !m_idle && m_cnt == 16;
  endfunction

  function automatic bit m_ready();
    return !m_idle && m_cnt < 16 && fsm_state == 3'b001;
  endfunction

  function automatic logic [77:0] expv();
    logic [6:0] st;
    st = {m_ready(), m_full(), 5'(m_cnt)};
    return {st, m_rd, st, bswap(m_rd)};
  endfunction

  // advance one edge and apply the block-loading rules to the model
  task automatic tick();
    @(posedge clock);
    if (reset) begin
      m_idle = 1'b1;
      m_cnt  = 0;
      m_rd   = '0;
      foreach (m_mem[i]) m_mem[i] = '0;
    end else begin
      m_rd = m_mem[rd_addr];
      if (m_idle) begin
        if (fsm_state == 3'b001) m_idle = 1'b0;
      end else if (fsm_state == 3'b000) begin
        m_idle = 1'b1;
        m_cnt  = 0;
      end else if (m_ready() && in_valid) begin
        m_mem[m_cnt] = in_data;
        m_cnt++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    fsm_state = 3'b000;
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({in_ready, stopw, word_count, rd_data} !== 39'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0",
               {in_ready, stopw, word_count, rd_data});
    end
    checks++;
    if (obs !== expv()) begin
      errors++;
      $display("FAIL reset_model got %h exp %h", obs, expv());
    end
  endtask

  task automatic test_basic_load();
    fsm_state = 3'b001;
    in_valid = 1'b1;
    in_data = '0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_ready got %b exp 1", in_ready);
    end
    for (int c = 0; c < 40 && !m_full(); c++) begin
      in_data = 32'(m_cnt);
      rd_addr = m_cnt[3:0];
      tick();
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL basic_obs got %h exp %h", obs, expv());
      end
    end
    checks++;
    if ({stopw, in_ready, word_count} !== {1'b1, 1'b0, 5'd16}) begin
      errors++;
      $display("FAIL basic_full got %b%b %0d exp 1 0 16",
               stopw, in_ready, word_count);
    end
    in_valid = 1'b0;
    rd_addr = 4'd5;
    tick();
    checks++;
    if (rd_data !== 32'h5 || rd_data_s !== 32'h0500_0000) begin
      errors++;
      $display("FAIL basic_read5 got %h %h exp 5 05000000",
               rd_data, rd_data_s);
    end
  endtask

  task automatic test_hold_release();
    in_valid = 1'b1;
    in_data = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      fsm_state = hs[k];
      rd_addr = 4'($urandom);
      tick();
      checks++;
      if (stopw !== 1'b1 || in_ready !== 1'b0 ||
          obs !== expv()) begin
        errors++;
        $display("FAIL hold_%0d got %h exp %h", k, obs, expv());
      end
    end
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      tick();
      checks++;
      if (rd_data !== 32'(a) || obs !== expv()) begin
        errors++;
        $display("FAIL hold_buf%0d got %h exp %h",
                 a, rd_data, 32'(a));
      end
    end
    fsm_state = 3'b000;
    in_valid = 1'b0;
    tick();
    checks++;
    if (stopw !== 1'b0 || word_count !== 5'd0 ||
        obs !== expv()) begin
      errors++;
      $display("FAIL release got %h exp %h", obs, expv());
    end
  endtask

  task automatic test_throttled();
    int acc;
    acc = 0;
    fsm_state = 3'b001;
    in_valid = 1'b0;
    tick();
    for (int c = 0; c < 64 && !m_full(); c++) begin
      in_valid = (c % 2 == 0);
      in_data = $urandom;
      rd_addr = 4'($urandom);
      if (in_valid && m_ready()) acc++;
      tick();
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL throttle_obs got %h exp %h", obs, expv());
      end
    end
    checks++;
    if (acc != 16 || stopw !== 1'b1) begin
      errors++;
      $display("FAIL throttle_accepts got %0d stopw %b exp 16 1",
               acc, stopw);
    end
    in_valid = 1'b0;
    fsm_state = 3'b000;
    tick();
  endtask

  task automatic test_byte_swap();
    fsm_state = 3'b001;
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    for (int c = 0; c < 40 && !m_full(); c++) begin
      in_data = (m_cnt == 0) ? 32'h1122_3344 : $urandom;
      tick();
    end
    in_valid = 1'b0;
    rd_addr = 4'd0;
    tick();
    checks++;
    if (rd_data_s !== 32'h4433_2211 ||
        rd_data !== 32'h1122_3344) begin
      errors++;
      $display("FAIL swap_word0 got %h %h exp 44332211 11223344",
               rd_data_s, rd_data);
    end
    for (int a = 1; a < 16; a++) begin
      rd_addr = 4'(a);
      tick();
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL swap_buf%0d got %h exp %h", a, obs, expv());
      end
    end
    fsm_state = 3'b000;
    tick();
  endtask

  task automatic test_abort();
    fsm_state = 3'b001;
    tick();
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_data = 32'hA000_0000 + 32'(i);
      tick();
    end
    fsm_state = 3'b000;
    in_data = 32'hFFFF_FFFF;
    tick();
    checks++;
    if (word_count !== 5'd0 || in_ready !== 1'b0 ||
        stopw !== 1'b0 || obs !== expv()) begin
      errors++;
      $display("FAIL abort_idle got %h exp %h", obs, expv());
    end
    fsm_state = 3'b001;
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data = 32'hB000_0000 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    for (int a = 0; a < 8; a++) begin
      rd_addr = 4'(a);
      tick();
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL abort_buf%0d got %h exp %h", a, obs, expv());
      end
    end
    rd_addr = 4'd0;
    tick();
    checks++;
    if (rd_data !== 32'hB000_0000 || word_count !== 5'd2) begin
      errors++;
      $display("FAIL abort_restart got %h %0d exp b0000000 2",
               rd_data, word_count);
    end
    fsm_state = 3'b000;
    tick();
  endtask

  task automatic test_reset_mid();
    fsm_state = 3'b001;
    tick();
    in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_data = $urandom;
      tick();
    end
    reset = 1'b1;
    in_data = $urandom;
    tick();
    checks++;
    if (word_count !== 5'd0 || stopw !== 1'b0 ||
        rd_data !== 32'h0 || obs !== expv()) begin
      errors++;
      $display("FAIL rstmid_out got %h exp %h", obs, expv());
    end
    reset = 1'b0;
    in_valid = 1'b0;
    fsm_state = 3'b000;
    rd_addr = 4'd3;
    tick();
    checks++;
    if (rd_data !== 32'h0 || rd_data_s !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_buf3 got %h %h exp 0",
               rd_data, rd_data_s);
    end
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 9);
      fsm_state = (r < 7) ? 3'b001 :
                  (r == 7) ? 3'b000 : 3'($urandom);
      in_valid = 1'($urandom);
      in_data = $urandom;
      rd_addr = 4'($urandom);
      reset = ($urandom_range(0, 149) == 0);
      tick();
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL random_c%0d got %h exp %h", c, obs, expv());
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_hold_release();
    test_throttled();
    test_byte_swap();
    test_abort();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
